// File: rtl/tl_rx_pkg.sv
// Shared definitions for the TL RX path: TC field geometry and the VC index type.
package tl_rx_pkg;
   localparam int unsigned TC_W       = 3;
   localparam int unsigned TC_NUM     = 8;
   localparam int unsigned TC_LSB_DEF = 20;
   localparam int unsigned N_VC_DEF   = 2;
   localparam int unsigned VC_IDX_W   = $clog2(N_VC_DEF) + 1;

   typedef logic [VC_IDX_W-1:0] vc_idx;
endpackage

// File: rtl/tl_rx_vc_buf.sv
// Per-VC synchronous FIFO: push side exposes full/count, pop side a valid/ready head.
module tl_rx_vc_buf #(
   parameter int unsigned DATA_SIZE = 32,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push_i,
   input  logic [DATA_SIZE-1:0]           push_data_i,
   output logic                           full_o,
   output logic [$clog2(BUF_DEPTH):0]     count_o,
   output logic                           valid_o,
   input  logic                           ready_i,
   output logic [DATA_SIZE-1:0]           data_o
);
   localparam int unsigned PTR_W  = $clog2(BUF_DEPTH);
   localparam int unsigned BCNT_W = PTR_W + 1;

   logic [DATA_SIZE-1:0] mem [BUF_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [BCNT_W-1:0]    count;
   logic                 wr;
   logic                 pop;

   always_comb begin
      full_o  = (count == BCNT_W'(BUF_DEPTH));
      valid_o = (count != '0);
      count_o = count;
      wr      = push_i && !full_o;
      pop     = valid_o && ready_i;
      // Gate the head so an empty buffer always presents zero, including after reset.
      data_o  = valid_o ? mem[rd_ptr] : '0;
   end

   always_ff @(posedge clk) begin
      if (wr) begin
         mem[wr_ptr] <= push_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/tl_rx_vc_router.sv
// TL RX single-stream to multi-VC demultiplexer: TC -> VC mapping, per-VC buffering,
// and a saturating counter of words discarded for disabled or out-of-range VCs.
module tl_rx_vc_router
   import tl_rx_pkg::*;
#(
   parameter int unsigned N_VC      = 2,
   parameter int unsigned DATA_SIZE = 32,
   parameter int unsigned TC_LSB    = TC_LSB_DEF,
   parameter int unsigned BUF_DEPTH = 2,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [$clog2(N_VC):0]    tc_vc_map_i [TC_NUM],
   input  logic [N_VC-1:0]          vc_en_i,
   input  logic                     src_valid_i,
   output logic                     src_ready_o,
   input  logic [DATA_SIZE-1:0]     src_data_i,
   output logic                     dst_valid_o [N_VC],
   input  logic                     dst_ready_i [N_VC],
   output logic [DATA_SIZE-1:0]     dst_data_o  [N_VC],
   output logic                     drop_pulse_o,
   output logic [CNT_W-1:0]         drop_cnt_o
);
   localparam int unsigned SEL_W  = $clog2(N_VC);
   localparam int unsigned MAP_W  = SEL_W + 1;
   localparam int unsigned BCNT_W = $clog2(BUF_DEPTH) + 1;

   logic [TC_W-1:0]   tc;
   logic [MAP_W-1:0]  v;
   logic [SEL_W-1:0]  v_sel;
   logic              tgt_dis;
   logic              drop;
   logic [N_VC-1:0]   push;
   logic [N_VC-1:0]   full;
   logic [BCNT_W-1:0] count [N_VC];

   always_comb begin
      tc      = src_data_i[TC_LSB +: TC_W];
      v       = tc_vc_map_i[tc];
      v_sel   = v[SEL_W-1:0];
      tgt_dis = 1'b1;
      if (v < MAP_W'(N_VC)) begin
         tgt_dis = !vc_en_i[v_sel];
      end
   end

   // Ready uses only the registered count so dst_ready_i never reaches src_ready_o.
   always_comb begin
      src_ready_o = tgt_dis || (count[v_sel] < BCNT_W'(BUF_DEPTH));
      drop        = src_valid_i && tgt_dis;
   end

   for (genvar i = 0; i < N_VC; i++) begin : g_vc
      always_comb begin
         push[i] = src_valid_i && !tgt_dis && (v_sel == SEL_W'(i)) && !full[i];
      end

      tl_rx_vc_buf #(
         .DATA_SIZE (DATA_SIZE),
         .BUF_DEPTH (BUF_DEPTH)
      ) u_buf (
         .clk         (clk),
         .rst_n       (rst_n),
         .push_i      (push[i]),
         .push_data_i (src_data_i),
         .full_o      (full[i]),
         .count_o     (count[i]),
         .valid_o     (dst_valid_o[i]),
         .ready_i     (dst_ready_i[i]),
         .data_o      (dst_data_o[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_pulse_o <= 1'b0;
         drop_cnt_o   <= '0;
      end else begin
         drop_pulse_o <= drop;
         if (drop && (drop_cnt_o != '1)) begin
            drop_cnt_o <= drop_cnt_o + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_tl_rx_vc_router.sv
// Scoreboard bench for tl_rx_vc_router: per-VC expected-word queues filled on acceptance.
module tb_tl_rx_vc_router;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  map [8];
   logic [1:0]  vc_en;
   logic        src_valid;
   logic        src_ready;
   logic [31:0] src_data;
   logic        dst_valid [2];
   logic        dst_ready [2];
   logic [31:0] dst_data  [2];
   logic        drop_pulse;
   logic [3:0]  drop_cnt;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned exp_drop = 0;
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];

   always #5 clk = ~clk;

   tl_rx_vc_router #(
      .N_VC      (2),
      .DATA_SIZE (32),
      .TC_LSB    (20),
      .BUF_DEPTH (2),
      .CNT_W     (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tc_vc_map_i  (map),
      .vc_en_i      (vc_en),
      .src_valid_i  (src_valid),
      .src_ready_o  (src_ready),
      .src_data_i   (src_data),
      .dst_valid_o  (dst_valid),
      .dst_ready_i  (dst_ready),
      .dst_data_o   (dst_data),
      .drop_pulse_o (drop_pulse),
      .drop_cnt_o   (drop_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [2:0] tc, input logic [19:0] id);
      return {id[7:0] ^ 8'h5A, 1'b0, tc, id};
   endfunction

   function automatic void model_accept(input logic [31:0] w);
      logic [2:0] t;
      logic [1:0] m;
      t = w[22:20];
      m = map[t];
      if (m >= 2'd2 || !vc_en[m[0]]) begin
         if (exp_drop != 15) exp_drop++;
      end else if (m[0]) begin
         q1.push_back(w);
      end else begin
         q0.push_back(w);
      end
   endfunction

   // Scoreboard side: compare every popped head against the oldest expected word.
   always @(negedge clk) begin
      if (rst_n) begin
         if (dst_valid[0] && dst_ready[0]) begin
            if (q0.size() == 0) check_eq("vc0_extra_word", 32'(dst_valid[0]), 32'd0);
            else check_eq("vc0_data", dst_data[0], q0.pop_front());
         end
         if (dst_valid[1] && dst_ready[1]) begin
            if (q1.size() == 0) check_eq("vc1_extra_word", 32'(dst_valid[1]), 32'd0);
            else check_eq("vc1_data", dst_data[1], q1.pop_front());
         end
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w);
      int unsigned n;
      n = 0;
      src_data  = w;
      src_valid = 1'b1;
      @(negedge clk);
      while (!src_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!src_ready) begin
         check_eq("send_timeout", 32'(src_ready), 32'd1);
         @(posedge clk);
      end else begin
         @(posedge clk);
         model_accept(w);
      end
      #1;
      src_valid = 1'b0;
   endtask

   task automatic send_lat(input logic [31:0] w, input int unsigned v);
      send(w);
      @(negedge clk);
      check_eq("lat_valid", 32'(dst_valid[v]), 32'd1);
      check_eq("lat_data", dst_data[v], w);
      sync();
   endtask

   task automatic drain();
      repeat (8) sync();
      check_eq("drain_q0", q0.size(), 32'd0);
      check_eq("drain_q1", q1.size(), 32'd0);
   endtask

   initial begin
      logic [31:0] c;
      rst_n = 1'b0;
      src_valid = 1'b0;
      src_data = '0;
      vc_en = 2'b11;
      dst_ready[0] = 1'b1;
      dst_ready[1] = 1'b1;
      for (int i = 0; i < 8; i++) map[i] = 2'(i % 2);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      check_eq("rst_valid0", 32'(dst_valid[0]), 32'd0);
      check_eq("rst_valid1", 32'(dst_valid[1]), 32'd0);
      check_eq("rst_data0", dst_data[0], 32'd0);
      check_eq("rst_data1", dst_data[1], 32'd0);
      check_eq("rst_pulse", 32'(drop_pulse), 32'd0);
      check_eq("rst_cnt", 32'(drop_cnt), 32'd0);
      check_eq("rst_ready", 32'(src_ready), 32'd1);
      sync();

      // Basic routing with one-cycle latency
      send_lat(mk(3'd0, 20'h1), 0);
      send_lat(mk(3'd1, 20'h2), 1);
      send_lat(mk(3'd0, 20'h3), 0);
      drain();
      check_eq("basic_cnt", 32'(drop_cnt), 32'd0);

      // Full VC1 back-pressure and head-of-line blocking
      dst_ready[1] = 1'b0;
      send(mk(3'd1, 20'h11));
      send(mk(3'd1, 20'h12));
      c = mk(3'd3, 20'h13);
      src_data  = c;
      src_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_eq("full_stall", 32'(src_ready), 32'd0);
         check_eq("hol_vc0_idle", 32'(dst_valid[0]), 32'd0);
      end
      sync();
      dst_ready[1] = 1'b1;
      @(negedge clk);
      check_eq("full_pop_no_pass", 32'(src_ready), 32'd0);
      @(negedge clk);
      check_eq("ready_after_pop", 32'(src_ready), 32'd1);
      @(posedge clk);
      model_accept(c);
      #1;
      src_valid = 1'b0;
      send(mk(3'd2, 20'h14));
      drain();

      // Discard: disabled VC
      vc_en = 2'b01;
      send(mk(3'd1, 20'h21));
      @(negedge clk);
      check_eq("dis_pulse", 32'(drop_pulse), 32'd1);
      check_eq("dis_cnt", 32'(drop_cnt), exp_drop);
      check_eq("dis_vc1_idle", 32'(dst_valid[1]), 32'd0);
      @(negedge clk);
      check_eq("dis_pulse_end", 32'(drop_pulse), 32'd0);
      sync();

      // Discard: out-of-range map entry
      vc_en = 2'b11;
      map[2] = 2'd3;
      send(mk(3'd2, 20'h22));
      @(negedge clk);
      check_eq("oor_pulse", 32'(drop_pulse), 32'd1);
      check_eq("oor_cnt", 32'(drop_cnt), exp_drop);
      check_eq("oor_vc0_idle", 32'(dst_valid[0]), 32'd0);
      sync();

      // Saturation at 15
      for (int i = 0; i < 20; i++) send(mk(3'd2, 20'(32 + i)));
      @(negedge clk);
      check_eq("sat_cnt", 32'(drop_cnt), exp_drop);
      check_eq("sat_cnt_max", 32'(drop_cnt), 32'd15);
      sync();
      map[2] = 2'd0;
      drain();

      // Mid-operation reset flushes both buffers
      dst_ready[0] = 1'b0;
      dst_ready[1] = 1'b0;
      send(mk(3'd0, 20'h41));
      send(mk(3'd0, 20'h42));
      send(mk(3'd1, 20'h43));
      send(mk(3'd1, 20'h44));
      @(negedge clk);
      check_eq("pre_rst_valid0", 32'(dst_valid[0]), 32'd1);
      check_eq("pre_rst_valid1", 32'(dst_valid[1]), 32'd1);
      sync();
      rst_n = 1'b0;
      q0.delete();
      q1.delete();
      exp_drop = 0;
      sync();
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_valid0", 32'(dst_valid[0]), 32'd0);
      check_eq("mid_rst_valid1", 32'(dst_valid[1]), 32'd0);
      check_eq("mid_rst_cnt", 32'(drop_cnt), 32'd0);
      sync();
      dst_ready[0] = 1'b1;
      dst_ready[1] = 1'b1;
      repeat (5) sync();
      @(negedge clk);
      check_eq("post_rst_valid0", 32'(dst_valid[0]), 32'd0);
      check_eq("post_rst_valid1", 32'(dst_valid[1]), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
